// File: rtl/spi_slave_fl.sv
// SPI flash-style slave (CPHA=1). ss/sclk/mosi are oversampled in the clk domain and
// READ / WRITE / READ ID / READ STATUS frames are mapped onto a simple synchronous memory port.
module spi_slave_fl #(
  parameter int          CPOL         = 1,
  parameter int          MEM_AW       = 8,
  parameter int          DUMMY_CYCLES = 0,
  parameter logic [23:0] DEV_ID       = 24'hC22017
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi_dq0,
  output logic              miso_dq1,
  output logic              miso_oe,
  input  logic [7:0]        status_in,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_valid,
  output logic [7:0]        cmd,
  output logic [2:0]        state_dbg
);
  localparam logic [7:0]        OP_WRITE   = 8'h02;
  localparam logic [7:0]        OP_READ    = 8'h03;
  localparam logic [7:0]        OP_STATUS  = 8'h05;
  localparam logic [7:0]        OP_ID      = 8'h9F;
  localparam logic              IDLE_LVL   = (CPOL != 0);
  localparam logic [3:0]        DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
  localparam logic [MEM_AW-1:0] PTR_ONE    = MEM_AW'(1);

  typedef enum logic [2:0] {
    S_WAIT_SS = 3'd0, S_IDLE = 3'd1, S_CMD = 3'd2, S_ADDR = 3'd3,
    S_DUMMY   = 3'd4, S_TX   = 3'd5, S_RX  = 3'd6, S_IGNORE = 3'd7
  } state_t;

  state_t state, state_nx;

  logic [1:0]        ss_sync, sclk_sync, mosi_sync;
  logic              sclk_prev;
  logic              ss_s, sclk_s, mosi_s, lead, trail;
  logic [4:0]        bit_cnt;
  logic [2:0]        tx_bit;
  logic [3:0]        dummy_cnt;
  logic [1:0]        id_idx;
  logic [6:0]        shreg;
  logic [6:0]        tx_sh;
  logic [7:0]        tx_buf, tx_next, rx_byte;
  logic [MEM_AW-1:0] ptr, addr_lo;
  logic              rd_pend;

  // The ss synchronizer resets to "selected" so a frame already in progress at
  // reset release is not mistaken for a fresh one; WAIT_SS holds until ss is seen high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= 2'b00;
      sclk_sync <= {2{IDLE_LVL}};
      mosi_sync <= 2'b00;
      sclk_prev <= IDLE_LVL;
    end else begin
      ss_sync   <= {ss_sync[0], ss};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi_dq0};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign ss_s      = ss_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign lead      = IDLE_LVL ? (sclk_prev & ~sclk_s) : (~sclk_prev & sclk_s);
  assign trail     = IDLE_LVL ? (~sclk_prev & sclk_s) : (sclk_prev & ~sclk_s);
  assign rx_byte   = {shreg, mosi_s};
  assign addr_lo   = {ptr[MEM_AW-2:0], mosi_s};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_WAIT_SS;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ss_s) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nx = S_CMD;
        S_CMD: begin
          if (trail && bit_cnt == 5'd7) begin
            case (rx_byte)
              OP_WRITE, OP_READ: state_nx = S_ADDR;
              OP_ID, OP_STATUS:  state_nx = S_TX;
              default:           state_nx = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (trail && bit_cnt == 5'd23) begin
            if (cmd == OP_WRITE)       state_nx = S_RX;
            else if (DUMMY_CYCLES > 0) state_nx = S_DUMMY;
            else                       state_nx = S_TX;
          end
        end
        S_DUMMY: if (trail && dummy_cnt == DUMMY_LAST) state_nx = S_TX;
        default: state_nx = state;
      endcase
    end
  end

  // Byte presented at the next byte boundary. A READ prefetch may still be in
  // flight when the first data leading edge arrives, so rdata is forwarded directly.
  always_comb begin
    tx_next = 8'h00;
    case (cmd)
      OP_READ:   tx_next = rd_pend ? mem_rdata : tx_buf;
      OP_STATUS: tx_next = status_in;
      OP_ID: begin
        case (id_idx)
          2'd0:    tx_next = DEV_ID[23:16];
          2'd1:    tx_next = DEV_ID[15:8];
          2'd2:    tx_next = DEV_ID[7:0];
          default: tx_next = 8'h00;
        endcase
      end
      default:   tx_next = 8'h00;
    endcase
  end

  // Memory port: mem_re / mem_we are single-clk strobes with mem_addr (and
  // mem_wdata) valid in the same clk; read data must be presented the following clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      tx_bit    <= '0;
      dummy_cnt <= '0;
      id_idx    <= '0;
      shreg     <= '0;
      tx_sh     <= '0;
      tx_buf    <= '0;
      ptr       <= '0;
      rd_pend   <= 1'b0;
      miso_dq1  <= 1'b0;
      miso_oe   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd       <= '0;
    end else begin
      cmd_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rd_pend   <= mem_re;
      if (rd_pend) tx_buf <= mem_rdata;
      if (ss_s) begin
        bit_cnt   <= '0;
        tx_bit    <= '0;
        dummy_cnt <= '0;
        id_idx    <= '0;
        miso_oe   <= 1'b0;
        miso_dq1  <= 1'b0;
      end else if (trail) begin
        case (state)
          S_CMD: begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              cmd       <= rx_byte;
              cmd_valid <= 1'b1;
            end
          end
          S_ADDR: begin
            bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
            ptr     <= addr_lo;
            if (bit_cnt == 5'd23 && cmd == OP_READ) begin
              mem_re   <= 1'b1;
              mem_addr <= addr_lo;
              ptr      <= addr_lo + PTR_ONE;
            end
          end
          S_DUMMY: dummy_cnt <= dummy_cnt + 4'd1;
          S_RX: begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= rx_byte;
              ptr       <= ptr + PTR_ONE;
            end
          end
          default: ;
        endcase
      end else if (lead && state == S_TX) begin
        miso_oe <= 1'b1;
        tx_bit  <= tx_bit + 3'd1;
        if (tx_bit == 3'd0) begin
          miso_dq1 <= tx_next[7];
          tx_sh    <= tx_next[6:0];
          if (cmd == OP_READ) begin
            mem_re   <= 1'b1;
            mem_addr <= ptr;
            ptr      <= ptr + PTR_ONE;
          end
          if (cmd == OP_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
        end else begin
          miso_dq1 <= tx_sh[6];
          tx_sh    <= {tx_sh[5:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_fl.sv
// Bench for spi_slave_fl: a bench-side SPI master (CPOL=1, CPHA=1) drives directed frames;
// a flash model predicts memory writes, commands and returned bytes, checked every clk.
`timescale 1ns/1ps
module tb_spi_slave_fl;
  localparam int          HALF   = 4;
  localparam logic [23:0] DEV_ID = 24'hC22017;

  // ---------------- clock / reset / pins ----------------
  logic clk = 1'b0, rst = 1'b0, ss = 1'b1, ss8 = 1'b1, sclk = 1'b1, mosi = 1'b0;
  logic [7:0] status_in = 8'h00;
  always #5 clk = ~clk;

  logic       miso, miso_oe, mem_we, mem_re, cmd_valid;
  logic [7:0] mem_addr, mem_wdata, cmd, mem_rdata;
  logic [2:0] state_dbg;
  logic       miso8, miso_oe8, mem_we8, mem_re8, cmd_valid8;
  logic [7:0] mem_addr8, mem_wdata8, cmd8, mem_rdata8;
  logic [2:0] state_dbg8;

  spi_slave_fl u_dut (
    .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi_dq0(mosi),
    .miso_dq1(miso), .miso_oe(miso_oe), .status_in(status_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cmd_valid(cmd_valid), .cmd(cmd), .state_dbg(state_dbg)
  );

  spi_slave_fl #(.DUMMY_CYCLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .ss(ss8), .sclk(sclk), .mosi_dq0(mosi),
    .miso_dq1(miso8), .miso_oe(miso_oe8), .status_in(status_in),
    .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_we(mem_we8), .mem_re(mem_re8),
    .mem_rdata(mem_rdata8), .cmd_valid(cmd_valid8), .cmd(cmd8), .state_dbg(state_dbg8)
  );

  // Backing memory, one clk read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_re)  mem_rdata  <= mem[mem_addr];
    if (mem_re8) mem_rdata8 <= mem[mem_addr8];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_pass = 0;
  int we_count = 0, cv8_count = 0;
  logic [15:0] exp_we_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic [7:0]  rx_log[$];
  logic [7:0]  model_mem [256];
  bit rd_ok = 0, oe_ok = 0, oe8_ok = 0, sel8 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %0h expected no activity", name, act);
  endtask

  // Compare process: every clk, DUT activity must match what the model allows/expects.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        we_count++;
        if (exp_we_q.size() == 0) note_fail("we_unexpected", {mem_addr, mem_wdata});
        else check("we_addr_data", {mem_addr, mem_wdata}, exp_we_q.pop_front());
      end
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) note_fail("cmd_unexpected", cmd);
        else check("cmd_byte", cmd, exp_cmd_q.pop_front());
      end
      if (mem_we || mem_re) check("we_re_exclusive", {mem_we, mem_re} == 2'b11, 0);
      if (mem_re && !rd_ok)     note_fail("re_unexpected", mem_addr);
      if (miso_oe && !oe_ok)    note_fail("oe_unexpected", miso_oe);
      if (miso_oe8 && !oe8_ok)  note_fail("oe8_unexpected", miso_oe8);
      if (mem_we8)              note_fail("we8_unexpected", mem_addr8);
      if (cmd_valid8) cv8_count++;
    end
  end

  // Flash model: byte i of a response, from the command rules alone.
  function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [7:0] a, input int i);
    logic [7:0] idx;
    idx = a + 8'(i);
    case (op)
      8'h03:   return model_mem[idx];
      8'h9F:   return (i < 3) ? 8'(DEV_ID >> (8 * (2 - i))) : 8'h00;
      8'h05:   return status_in;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- driver tasks (SPI master, mode 3) ----------------
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sclk = 1'b0; mosi = tx[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1; rx[i] = sel8 ? miso8 : miso;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic begin_frame(input bit use8);
    sel8 = use8;
    if (use8) ss8 = 1'b0; else ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    ss = 1'b1; ss8 = 1'b1;
    repeat (8) @(negedge clk);
    rd_ok = 0; oe_ok = 0; oe8_ok = 0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a, input bit with_addr);
    logic [7:0] d;
    xfer(op, 8, d);
    if (with_addr) begin
      xfer(a[23:16], 8, d); xfer(a[15:8], 8, d); xfer(a[7:0], 8, d);
    end
  endtask

  task automatic read_bytes(input string name, input logic [7:0] op, input logic [7:0] a, input int n);
    logic [7:0] rx;
    rx_log.delete();
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, 8, rx);
      rx_log.push_back(rx);
      check(name, rx, model_byte(op, a, i));
    end
  endtask

  task automatic write_frame(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] a1, rx;
    a1 = a[7:0] + 8'd1;
    exp_cmd_q.push_back(8'h02);
    exp_we_q.push_back({a[7:0], d0}); model_mem[a[7:0]] = d0;
    exp_we_q.push_back({a1, d1});     model_mem[a1] = d1;
    begin_frame(0);
    send_hdr(8'h02, a, 1);
    xfer(d0, 8, rx); xfer(d1, 8, rx);
    end_frame();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] rx;
    int we_before;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_outputs", {miso, miso_oe, mem_we, mem_re, cmd_valid, mem_addr, mem_wdata, cmd}, 0);
    check("rst_state", state_dbg, 3'd0);
    check("rst_state8", state_dbg8, 3'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // 1: WRITE two bytes at 0x10
    write_frame(24'h000010, 8'hA5, 8'h5A);
    check("t1_we_done", exp_we_q.size(), 0);
    check("t1_mem10", mem[8'h10], 8'hA5);
    check("t1_mem11", mem[8'h11], 8'h5A);
    check("t1_cmd_held", cmd, 8'h02);

    // 2: READ them back, no dummy cycles
    exp_cmd_q.push_back(8'h03);
    begin_frame(0); rd_ok = 1; oe_ok = 1;
    send_hdr(8'h03, 24'h000010, 1);
    read_bytes("t2_read", 8'h03, 8'h10, 2);
    check("t2_lit0", rx_log[0], 8'hA5);
    check("t2_lit1", rx_log[1], 8'h5A);
    check("t2_oe", miso_oe, 1'b1);
    end_frame();
    check("t2_oe_drop", miso_oe, 1'b0);

    // 2b: READ with 8 dummy cycles on the second instance
    begin_frame(1);
    send_hdr(8'h03, 24'h000010, 1);
    xfer(8'h00, 8, rx);
    check("t2d_dummy_byte", rx, 8'h00);
    check("t2d_oe_in_dummy", miso_oe8, 1'b0);
    oe8_ok = 1;
    read_bytes("t2d_read", 8'h03, 8'h10, 2);
    check("t2d_lit0", rx_log[0], 8'hA5);
    check("t2d_lit1", rx_log[1], 8'h5A);
    end_frame();
    check("t2d_cmd8", cmd8, 8'h03);
    check("t2d_cmd_valid8", cv8_count, 1);

    // 3: WRITE wraps 0xFF -> 0x00
    write_frame(24'h0000FF, 8'h11, 8'h22);
    check("t3_we_done", exp_we_q.size(), 0);
    check("t3_memff", mem[8'hFF], 8'h11);
    check("t3_mem00", mem[8'h00], 8'h22);

    // 4: READ ID and READ STATUS
    exp_cmd_q.push_back(8'h9F);
    begin_frame(0); oe_ok = 1;
    send_hdr(8'h9F, 24'h0, 0);
    read_bytes("t4_id", 8'h9F, 8'h00, 4);
    check("t4_id_lit", {rx_log[0], rx_log[1], rx_log[2], rx_log[3]}, 32'hC2201700);
    end_frame();
    status_in = 8'h03;
    exp_cmd_q.push_back(8'h05);
    begin_frame(0); oe_ok = 1;
    send_hdr(8'h05, 24'h0, 0);
    read_bytes("t4_status", 8'h05, 8'h00, 2);
    check("t4_status_lit", {rx_log[0], rx_log[1]}, 16'h0303);
    end_frame();

    // 5: abort inside a WRITE data byte, then unknown command, then READ ID
    we_before = we_count;
    exp_cmd_q.push_back(8'h02);
    begin_frame(0);
    send_hdr(8'h02, 24'h000020, 1);
    xfer(8'hFF, 5, rx);
    end_frame();
    check("t5_abort_no_we", we_count, we_before);
    exp_cmd_q.push_back(8'hA3);
    begin_frame(0);
    send_hdr(8'hA3, 24'h0, 0);
    xfer(8'h00, 8, rx);
    check("t5_ignore_rx", rx, 8'h00);
    check("t5_ignore_oe", miso_oe, 1'b0);
    end_frame();
    check("t5_ignore_cmd", cmd, 8'hA3);
    exp_cmd_q.push_back(8'h9F);
    begin_frame(0); oe_ok = 1;
    send_hdr(8'h9F, 24'h0, 0);
    read_bytes("t5_id", 8'h9F, 8'h00, 3);
    end_frame();

    // 6: reset in the middle of a READ, release with ss still low
    exp_cmd_q.push_back(8'h03);
    begin_frame(0); rd_ok = 1; oe_ok = 1;
    send_hdr(8'h03, 24'h000010, 1);
    read_bytes("t6_read", 8'h03, 8'h10, 1);
    xfer(8'h00, 4, rx);
    rst = 1'b0;
    #1;
    check("t6_rst_outputs", {miso, miso_oe, mem_we, mem_re, cmd_valid, mem_addr, mem_wdata, cmd}, 0);
    repeat (2) @(negedge clk);
    rd_ok = 0; oe_ok = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'h03, 8, rx);
    check("t6_silent_rx0", rx, 8'h00);
    xfer(8'h03, 8, rx);
    check("t6_silent_rx1", rx, 8'h00);
    check("t6_silent_oe", miso_oe, 1'b0);
    end_frame();
    status_in = 8'h5C;
    exp_cmd_q.push_back(8'h05);
    begin_frame(0); oe_ok = 1;
    send_hdr(8'h05, 24'h0, 0);
    read_bytes("t6_status", 8'h05, 8'h00, 2);
    check("t6_status_lit", rx_log[1], 8'h5C);
    end_frame();

    check("end_we_queue", exp_we_q.size(), 0);
    check("end_cmd_queue", exp_cmd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
